// File: rtl/p2s_stream_if.sv
// Word-load handshake into the parallel-to-serial converter.
interface p2s_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] par_in;
  logic             load_valid;
  logic             load_ready;

  modport master (output par_in, output load_valid, input load_ready);
  modport slave  (input par_in, input load_valid, output load_ready);
endinterface

// File: rtl/p2s_stream.sv
// Parallel-to-serial converter with a one-word holding register so that
// consecutive words stream out with no idle bit between them.
module p2s_stream #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  p2s_stream_if.slave  load,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         eoc,
  output logic         busy
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_q, ser_d;
  logic             accept, last, do_load;
  logic [WIDTH-1:0] load_word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign load.load_ready = !hold_full_q && !reset;
  assign accept          = load.load_valid && load.load_ready;
  assign last            = (state_q == SHIFT) && (cnt_q == LAST);

  // A new word enters the shifter straight from idle, or at the final-bit
  // edge from the hold register (preferred) or a same-edge accept.
  assign do_load   = ((state_q == IDLE) && accept) || (last && (hold_full_q || accept));
  assign load_word = hold_full_q ? hold_q : load.par_in;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    ser_d       = ser_q;
    if (do_load) begin
      state_d     = SHIFT;
      ser_d       = first_bit(load_word);
      shreg_d     = advance(load_word);
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else if ((state_q == SHIFT) && !last) begin
      ser_d   = first_bit(shreg_q);
      shreg_d = advance(shreg_q);
      cnt_d   = cnt_q + CW'(1);
      if (accept) begin
        hold_d      = load.par_in;
        hold_full_d = 1'b1;
      end
    end else if (state_q == SHIFT) begin
      state_d = IDLE;
      ser_d   = IDLE_LEVEL;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      ser_q       <= IDLE_LEVEL;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      ser_q       <= ser_d;
    end
  end

  assign ser_out   = ser_q;
  assign ser_valid = (state_q == SHIFT);
  assign eoc       = last;
  assign busy      = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_p2s_stream.sv
// Directed self-checking bench for p2s_stream: MSB/LSB-first, WIDTH=2 with
// idle-high, back-to-back streaming, sustained load and mid-word reset.
module tb_p2s_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A: WIDTH=8 MSB-first; B: WIDTH=8 LSB-first; C: WIDTH=2 idle-high
  p2s_stream_if #(.WIDTH(8)) ifa ();
  p2s_stream_if #(.WIDTH(8)) ifb ();
  p2s_stream_if #(.WIDTH(2)) ifc ();

  logic a_ser, a_sv, a_eoc, a_busy;
  logic b_ser, b_sv, b_eoc, b_busy;
  logic c_ser, c_sv, c_eoc, c_busy;

  p2s_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .load(ifa),
    .ser_out(a_ser), .ser_valid(a_sv), .eoc(a_eoc), .busy(a_busy));

  p2s_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .load(ifb),
    .ser_out(b_ser), .ser_valid(b_sv), .eoc(b_eoc), .busy(b_busy));

  p2s_stream #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_c (
    .clk(clk), .reset(reset), .load(ifc),
    .ser_out(c_ser), .ser_valid(c_sv), .eoc(c_eoc), .busy(c_busy));

  initial begin
    logic [7:0]  wa;
    logic [1:0]  wc;
    logic [15:0] stream;
    logic [7:0]  q[$];
    logic [7:0]  rx_word, exp_word, next_word;
    int          exp_edges[6];
    int          nacc, nbits, nrx, gaps, eocs, svs;
    bit          seen, acc;

    reset = 1'b1;
    ifa.load_valid = 1'b0; ifa.par_in = '0;
    ifb.load_valid = 1'b0; ifb.par_in = '0;
    ifc.load_valid = 1'b0; ifc.par_in = '0;
    tick();
    tick();

    // Reset state
    check("rst_a_ser",   a_ser, 1'b0);
    check("rst_a_sv",    a_sv, 1'b0);
    check("rst_a_eoc",   a_eoc, 1'b0);
    check("rst_a_busy",  a_busy, 1'b0);
    check("rst_a_ready", ifa.load_ready, 1'b0);
    check("rst_c_ser",   c_ser, 1'b1);
    check("rst_c_sv",    c_sv, 1'b0);
    reset = 1'b0;
    #1;
    check("a_ready_after_rst", ifa.load_ready, 1'b1);

    // Single word on all three instances, accepted at edge 0
    wa = 8'hA5;
    wc = 2'b01;
    ifa.par_in = wa;  ifa.load_valid = 1'b1;
    ifb.par_in = wa;  ifb.load_valid = 1'b1;
    ifc.par_in = wc;  ifc.load_valid = 1'b1;
    tick();
    ifa.load_valid = 1'b0; ifb.load_valid = 1'b0; ifc.load_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) begin
        check("a_ser", a_ser, wa[8-k]);
        check("b_ser", b_ser, wa[k-1]);
      end else begin
        check("a_ser_idle", a_ser, 1'b0);
        check("b_ser_idle", b_ser, 1'b0);
      end
      check("a_sv",   a_sv,   k <= 8);
      check("a_eoc",  a_eoc,  k == 8);
      check("a_busy", a_busy, k <= 8);
      check("b_eoc",  b_eoc,  k == 8);
      if (k <= 2) check("c_ser", c_ser, wc[2-k]);
      else        check("c_ser_idle", c_ser, 1'b1);
      check("c_sv",  c_sv,  k <= 2);
      check("c_eoc", c_eoc, k == 2);
      tick();
    end

    // Back-to-back: 0xF0 at edge 0, 0x0F at edge 2
    stream = 16'hF00F;
    ifa.par_in = 8'hF0; ifa.load_valid = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      if (k == 2) begin
        ifa.par_in = 8'h0F; ifa.load_valid = 1'b1;
      end else begin
        ifa.load_valid = 1'b0;
      end
      if (k <= 16) check("b2b_ser", a_ser, stream[16-k]);
      else         check("b2b_ser_idle", a_ser, 1'b0);
      check("b2b_sv",    a_sv, k <= 16);
      check("b2b_eoc",   a_eoc, (k == 8) || (k == 16));
      check("b2b_ready", ifa.load_ready, !(k >= 3 && k <= 8));
      tick();
    end

    // Sustained load_valid with a fresh word after every accept
    exp_edges = '{0, 1, 9, 17, 25, 33};
    nacc = 0; nbits = 0; nrx = 0; gaps = 0; seen = 0;
    rx_word = '0;
    next_word = 8'h3C;
    ifa.par_in = next_word;
    ifa.load_valid = 1'b1;
    for (int e = 0; e < 140; e++) begin
      if (e == 40) ifa.load_valid = 1'b0;
      acc = ifa.load_valid && ifa.load_ready;
      tick();
      if (acc) begin
        if (nacc < 6) check("hold_acc_edge", e, exp_edges[nacc]);
        else          check("hold_acc_extra", nacc, 5);
        q.push_back(ifa.par_in);
        nacc++;
        next_word = next_word + 8'h57;
        ifa.par_in = next_word;
      end
      if (a_sv) begin
        seen = 1;
        rx_word = {rx_word[6:0], a_ser};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          exp_word = (q.size() > 0) ? q.pop_front() : 8'hxx;
          check("hold_word", rx_word, exp_word);
          nrx++;
        end
      end else if (seen && nrx < 6) begin
        gaps++;
      end
      if (nrx == 6 && !a_busy) break;
    end
    check("hold_acc_count", nacc, 6);
    check("hold_rx_count", nrx, 6);
    check("hold_gaps", gaps, 0);

    // Reset mid-word with a word also held
    ifa.par_in = 8'hFF; ifa.load_valid = 1'b1;
    tick();
    ifa.par_in = 8'h81;
    tick();
    ifa.load_valid = 1'b0;
    check("mid_busy",  a_busy, 1'b1);
    check("mid_ready", ifa.load_ready, 1'b0);
    tick();
    check("mid_ser", a_ser, 1'b1);
    reset = 1'b1;
    tick();
    check("rst4_ser",   a_ser, 1'b0);
    check("rst4_sv",    a_sv, 1'b0);
    check("rst4_busy",  a_busy, 1'b0);
    check("rst4_eoc",   a_eoc, 1'b0);
    check("rst4_ready", ifa.load_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("rst4_ready_rel", ifa.load_ready, 1'b1);
    eocs = 0; svs = 0;
    for (int k = 0; k < 12; k++) begin
      if (a_eoc) eocs++;
      if (a_sv)  svs++;
      tick();
    end
    check("rst_no_eoc", eocs, 0);
    check("rst_no_sv",  svs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/p2s_stream.md
# p2s_stream

Parametrised parallel-to-serial converter: accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB- or LSB-first. A one-word holding register lets consecutive words stream with no idle bit between them. It replaces the fixed 4-bit load/shift converter in serial transmit paths. It is also the bit source for the line-coding and framing blocks downstream.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
- IDLE_LEVEL, 0, level driven on ser_out when no bit is valid.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- par_in  in  WIDTH  word to serialise; sampled only on accept.
- load_valid  in  1  par_in holds a word.
- load_ready  out  1  block can take a word this cycle; combinational, equal to (!hold_full && !reset).
- ser_out  out  1  registered serial bit.
- ser_valid  out  1  ser_out carries a data bit this cycle.
- eoc  out  1  one-cycle pulse, high while the last bit of a word is on ser_out.
- busy  out  1  high while shifting or while a word is held.

## Operation
- Accept happens when load_valid && load_ready at a rising edge.
- State machine:
  - IDLE to SHIFT on accept. The word goes directly into the shift register, and the first bit is registered onto ser_out at that same edge.
  - In SHIFT, bit_cnt (width clog2(WIDTH)) counts 0..WIDTH-1. Each edge presents the next bit.
  - At the edge that ends the last bit, if the hold register is full, its word loads into the shifter. The first bit of that word appears on the next cycle, with no gap, and hold_full clears.
  - At the same edge, if the hold register is empty but an accept occurs, the incoming word loads directly into the shifter with no gap.
  - If neither applies, the block returns to IDLE.
- An accept while in SHIFT, other than at the final-bit edge described above, writes the hold register and sets hold_full. load_ready therefore drops on the following cycle.
- Only one word can be held. An accept and a hold drain cannot both target the hold register, because load_ready is 0 whenever the hold register is full.
- Shift direction:
  - MSB_FIRST=1: shift left, output the top bit.
  - MSB_FIRST=0: shift right, output bit 0.
- When ser_valid is 0, ser_out equals IDLE_LEVEL.
- par_in and load_valid are ignored when no accept occurs. Words are never dropped or duplicated.

## Timing
- Reset values, applied at the first edge with reset=1: ser_out=IDLE_LEVEL, ser_valid=0, eoc=0, busy=0, hold_full=0, state=IDLE, bit_cnt=0.
- load_ready is 0 while reset is high.
- Reset asserted mid-word aborts that word and discards the held word. The next cycle is idle output.
- Latency: a word accepted at edge N has its first bit on ser_out during cycle N+1 and its last bit during cycle N+WIDTH. eoc is high during cycle N+WIDTH only.
- Sustained throughput is one word per WIDTH cycles. ser_valid stays continuously high across back-to-back words.
- busy is high from the cycle after the first accept until the cycle after the final eoc, inclusive of the eoc cycle.

## Test plan
- WIDTH=8, MSB_FIRST=1: accept 0xA5 at edge 0 -> ser_out = 1,0,1,0,0,1,0,1 on cycles 1..8, ser_valid high on cycles 1..8, eoc only on cycle 8, IDLE_LEVEL from cycle 9.
- WIDTH=8, MSB_FIRST=0: accept 0xA5 -> ser_out = 1,0,1,0,0,1,0,1 (bits 0..7), eoc on cycle 8.
- Back-to-back: accept 0xF0 at edge 0 and 0x0F at edge 2 -> load_ready low on cycles 3..8. Output is 16 continuous valid bits, 11110000 then 00001111. eoc on cycles 8 and 16.
- Holding limit: load_valid held high with a new word each cycle from edge 0 -> exactly one word accepted per 8 cycles after the first two. No ser_valid gap. Scoreboard matches every accepted word.
- Reset mid-word: accept 0xFF, assert reset at edge 3 for one cycle -> cycle 4 shows ser_out=IDLE_LEVEL, ser_valid=0, busy=0, load_ready=1 after reset deasserts. No eoc.
- WIDTH=2, IDLE_LEVEL=1: accept 2'b01 -> ser_out = 0,1 then idles high. eoc on cycle 2.
